// File: rtl/sfp_resize_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sfp_resize_arbiter_if
// Purpose  : Request, result and statistics bundle for sfp_resize_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sfp_resize_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int IN_WL  = 24,
    parameter int OUT_WL = 16,
    parameter int ID_W   = 2,
    parameter int CNT_W  = 16
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*IN_WL-1:0] req_val;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_WL-1:0]      out_val;
    logic [ID_W-1:0]        out_id;
    logic                   out_clip;
    logic [N_REQ-1:0]       clip_sticky;
    logic [CNT_W-1:0]       clip_count;
    logic                   clr_stats;

    modport slave (
        input  req_valid, req_val, out_ready, clr_stats,
        output req_ready, out_valid, out_val, out_id, out_clip, clip_sticky, clip_count
    );

    modport master (
        output req_valid, req_val, out_ready, clr_stats,
        input  req_ready, out_valid, out_val, out_id, out_clip, clip_sticky, clip_count
    );
endinterface
`default_nettype wire

// File: rtl/sfp_resize_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sfp_resize_arbiter
// Purpose  : Round-robin shared signed fixed-point resize with clip statistics.
// Revision : 1.0 - initial release
// ============================================================================
module sfp_resize_arbiter #(
    parameter int N_REQ  = 4,
    parameter int IN_IW  = 8,
    parameter int IN_QW  = 16,
    parameter int OUT_IW = 4,
    parameter int OUT_QW = 12,
    parameter bit CLIP   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    sfp_resize_arbiter_if.slave   bus
);
    localparam int IN_WL  = IN_IW + IN_QW;
    localparam int OUT_WL = OUT_IW + OUT_QW;
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Fraction already aligned to OUT_QW, integer part still IN_IW wide
    localparam int MID_WL = IN_IW + OUT_QW;

    logic [ID_W-1:0]   r_ptr;
    logic              r_out_valid;
    logic [OUT_WL-1:0] r_out_val;
    logic [ID_W-1:0]   r_out_id;
    logic              r_out_clip;
    logic [N_REQ-1:0]  r_clip_sticky;
    logic [CNT_W-1:0]  r_clip_count;

    logic              w_accept;
    logic              w_any;
    logic              w_hs;
    logic [ID_W-1:0]   w_gnt_id;
    logic [N_REQ-1:0]  w_ready;
    logic [MID_WL-1:0] w_mid;
    logic [OUT_WL-1:0] w_res;
    logic              w_clip;

    assign w_accept = !r_out_valid || bus.out_ready;

    always_comb begin
        int idx;
        w_any    = 1'b0;
        w_gnt_id = '0;
        idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(r_ptr) + k) % N_REQ;
            if (!w_any && bus.req_valid[idx]) begin
                w_any    = 1'b1;
                w_gnt_id = ID_W'(idx);
            end
        end
    end

    assign w_hs = w_any && w_accept && !rst;

    always_comb begin
        w_ready = '0;
        if (w_hs) begin
            w_ready[w_gnt_id] = 1'b1;
        end
    end

    assign bus.req_ready = w_ready;

    // Fraction alignment: dropping LSBs of a two's complement value is a floor
    generate
        if (OUT_QW < IN_QW) begin : g_frac_trunc
            assign w_mid = bus.req_val[int'(w_gnt_id)*IN_WL + (IN_QW-OUT_QW) +: MID_WL];
        end else begin : g_frac_pad
            assign w_mid = MID_WL'(bus.req_val[int'(w_gnt_id)*IN_WL +: IN_WL]) << (OUT_QW - IN_QW);
        end
    endgenerate

    generate
        if (OUT_IW >= IN_IW) begin : g_int_ext
            assign w_res  = OUT_WL'($signed(w_mid));
            assign w_clip = 1'b0;
        end else begin : g_int_narrow
            logic [MID_WL-OUT_WL:0] w_hi;
            logic                   w_ovf;
            assign w_hi  = w_mid[MID_WL-1:OUT_WL-1];
            assign w_ovf = !((&w_hi) || !(|w_hi));
            if (CLIP) begin : g_sat
                assign w_res  = !w_ovf ? w_mid[OUT_WL-1:0] :
                                w_mid[MID_WL-1] ? {1'b1, {(OUT_WL-1){1'b0}}} :
                                                  {1'b0, {(OUT_WL-1){1'b1}}};
                assign w_clip = w_ovf;
            end else begin : g_wrap
                assign w_res  = w_mid[OUT_WL-1:0];
                assign w_clip = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= ID_W'(N_REQ - 1);
            r_out_valid <= 1'b0;
            r_out_val   <= '0;
            r_out_id    <= '0;
            r_out_clip  <= 1'b0;
        end else if (w_hs) begin
            r_ptr       <= w_gnt_id;
            r_out_valid <= 1'b1;
            r_out_val   <= w_res;
            r_out_id    <= w_gnt_id;
            r_out_clip  <= w_clip;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr_stats) begin
            r_clip_sticky <= '0;
            r_clip_count  <= '0;
        end else if (w_hs && w_clip) begin
            r_clip_sticky[w_gnt_id] <= 1'b1;
            if (r_clip_count != {CNT_W{1'b1}}) begin
                r_clip_count <= r_clip_count + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_val     = r_out_val;
    assign bus.out_id      = r_out_id;
    assign bus.out_clip    = r_out_clip;
    assign bus.clip_sticky = r_clip_sticky;
    assign bus.clip_count  = r_clip_count;
endmodule
`default_nettype wire

// File: doc/sfp_resize_arbiter.md
Name: sfp_resize_arbiter

Overview:
- Shares one signed fixed-point resize datapath among N_REQ requesters.
- Each requester presents a signed IN_IW.IN_QW value with a valid/ready handshake. A round-robin arbiter grants one requester per cycle.
- The value is resized to OUT_IW.OUT_QW and registered on a single output channel. The output carries the requester id and a clip flag.
- Keeps per-requester sticky clip flags and a global clip-event counter for the shader/normalise stages that feed narrower downstream math.

Parameters:
- N_REQ, 4: number of requesters (2..16).
- IN_IW, 8: input integer bits, sign included.
- IN_QW, 16: input fractional bits.
- OUT_IW, 4: output integer bits, sign included.
- OUT_QW, 12: output fractional bits.
- CLIP, 1: applies when OUT_IW < IN_IW. 1 = saturate, 0 = wrap (drop MSBs).
- CNT_W, 16: clip event counter width.
- Derived values: IN_WL = IN_IW+IN_QW, OUT_WL = OUT_IW+OUT_QW, ID_W = max(1, clog2(N_REQ)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester valid.
- req_ready  out  N_REQ  per-requester ready. Asserted only on the granted bit.
- req_val  in  N_REQ*IN_WL  packed signed inputs; requester i occupies bits [i*IN_WL +: IN_WL].
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- out_val  out  OUT_WL  resized signed value.
- out_id  out  ID_W  index of the source requester.
- out_clip  out  1  saturation occurred on this result (always 0 when CLIP=0 or OUT_IW >= IN_IW).
- clip_sticky  out  N_REQ  per-requester sticky clip flag.
- clip_count  out  CNT_W  number of clip events.
- clr_stats  in  1  clears clip_sticky and clip_count.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_val=0, out_id=0, out_clip=0.
  - clip_sticky=0, clip_count=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has top priority first.
  - req_ready=0 while rst is high.
  - Reset mid-transfer discards the held output; there is no partial state.
- Accept condition: accept = !out_valid || out_ready. This gives full throughput of one result per cycle with a single output register; there is no skid buffer.
- Arbitration (combinational within the cycle):
  - If accept is true and any req_valid is set, grant the first set bit searching from ptr+1 upward, modulo N_REQ.
  - req_ready[g]=1 for the grant only; all other req_ready bits are 0. req_ready never depends on out_ready except through accept.
  - On a handshake (req_valid[g] && req_ready[g]): ptr <= g.
  - When there is no request, ptr holds.
- Datapath, one-cycle latency (handshake at edge k -> out_valid=1 after edge k):
  - Fractional bits:
    - OUT_QW < IN_QW: truncate LSBs, i.e. floor toward -inf.
    - OUT_QW > IN_QW: zero-pad LSBs.
  - Integer bits:
    - OUT_IW > IN_IW: sign-extend.
    - OUT_IW < IN_IW with CLIP=1: a value outside the range saturates to +max (0111..1) or -min (1000..0), and out_clip=1.
    - OUT_IW < IN_IW with CLIP=0: MSBs are discarded, out_clip=0.
  - Ordering: truncate first, then clip/wrap. Result equals floor(x*2^OUT_QW) saturated to OUT_WL bits.
- Output hold:
  - While out_valid && !out_ready, out_val, out_id and out_clip are stable.
  - On an edge with out_ready=1 and no new handshake: out_valid <= 0.
  - Data fields keep their last values when out_valid=0.
- Statistics, updated at the handshake edge when the resized value clips:
  - clip_sticky[g] <= 1.
  - clip_count increments and saturates at 2^CNT_W-1, with no wrap.
  - clr_stats=1 clears both and has priority over a same-cycle clip event, which is not counted.

Test Plan:
- Reset release with all req_valid=1 -> grant order over consecutive cycles is 0,1,2,3,0, with out_ready=1 throughout; out_id follows the same sequence with one-cycle lag.
- Req1 sends 0x038000 (3.5 in 8.16) -> out_val=0x3800, out_clip=0, out_valid one cycle after the handshake.
- Req2 sends 0x0A0000 (+10.0) then 0xF60000 (-10.0) -> out_val 0x7FFF then 0x8000, out_clip=1 both; clip_sticky=4'b0100, clip_count=2. Repeat with CLIP=0 -> 0xA000 then 0x6000, out_clip=0, count stays 0.
- Req0 sends 0xFFFFFF (-2^-16) -> out_val=0xFFFF (floor to -2^-12), no clip.
- out_ready=0 for 5 cycles with requests pending -> first result held stable, all req_ready=0 after it is captured, no requests lost; on release, results drain in round-robin order.
- Assert clr_stats in the same cycle as a clipping handshake -> clip_count=0, clip_sticky=0. CNT_W=2 with 5 clips -> clip_count=3. rst asserted while out_valid=1 -> next cycle out_valid=0, ptr restarts at requester 0.
